lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 7: register width, legal range 3..32.
REQ-002 Parameter TAPS, default 7'b1000100 (WIDTH bits): feedback tap mask; bit i set means sreg[i] feeds the XOR.
REQ-003 Parameter SEED, default 1: reset and zero-substitute value; SHALL be nonzero.
REQ-004 Parameter LEN_W, default 8: width of burst_len.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  free-run step enable; valid only while the FSM is in IDLE.
REQ-008 load  in  1  load seed_in into the register.
REQ-009 seed_in  in  WIDTH  seed value for load.
REQ-010 burst_start  in  1  request a burst of burst_len steps.
REQ-011 burst_len  in  LEN_W  burst step count, sampled with burst_start.
REQ-012 data_out  out  WIDTH  current register value.
REQ-013 busy  out  1  high while in BURST.
REQ-014 done  out  1  one-cycle pulse when a burst completes.
REQ-015 wrap  out  1  one-cycle pulse on the step that returns the register to the origin.
REQ-016 period  out  WIDTH  step count of the last completed cycle.
REQ-017 seed_err  out  1  one-cycle pulse when a zero seed was substituted.

Function
REQ-018 Step: sreg <= {sreg[WIDTH-2:0], fb}; fb = XOR of sreg[i] over all i with TAPS[i]=1.
REQ-019 Priority: load > burst stepping > en; at most one step per cycle.
REQ-020 load: sreg <= seed_in, or SEED if seed_in==0, with seed_err=1 on the next cycle; origin <= the loaded value; step_cnt <= 0; no step that cycle.
REQ-021 FSM states IDLE, BURST, DONE.
REQ-022 IDLE + burst_start with burst_len>0 -> BURST; remaining <= burst_len; no step in the transition cycle.
REQ-023 IDLE + burst_start with burst_len==0 -> DONE; no step.
REQ-024 BURST: step every cycle; en ignored; decrement remaining; after the last step -> DONE.
REQ-025 DONE: done=1 for exactly one cycle -> IDLE.
REQ-026 burst_start is ignored outside IDLE.
REQ-027 load in BURST or DONE: abort to IDLE with no done pulse; the load is applied per REQ-020.
REQ-028 In IDLE, en=1 steps once per cycle.
REQ-029 step_cnt (WIDTH bits) increments on each step.
REQ-030 When a step yields sreg_next==origin: wrap=1 on the next cycle; period <= step_cnt+1; step_cnt <= 0.
REQ-031 step_cnt saturates at all-ones; with a primitive TAPS it never saturates.
REQ-032 wrap, done and seed_err are registered outputs, each high for exactly one cycle per event.

Reset
REQ-033 On rst_n low, asynchronously: sreg=SEED, origin=SEED, step_cnt=0, period=0, FSM=IDLE, busy=0, done=0, wrap=0, seed_err=0.
REQ-034 Reset during BURST abandons the burst with no done pulse.
REQ-035 Outputs SHALL be stable and valid from the first edge after rst_n deasserts.

Structure
REQ-036 Package lfsr_pkg SHALL hold the FSM state enum (IDLE/BURST/DONE) and the default tap constant for WIDTH=7.
REQ-037 Sub-module lfsr_step SHALL be a combinational next-state function (WIDTH, TAPS) instantiated once.
REQ-038 No other hierarchy.

Verification (WIDTH=7, TAPS=7'b1000100, SEED=1)
REQ-039 After reset, en=1 for 3 cycles -> data_out goes 0x02, 0x04, 0x09.
REQ-040 After reset, en=1 for 127 cycles -> wrap pulses once on the 127th step, data_out=0x01, period=127.
REQ-041 After reset, burst_start with burst_len=5 -> busy high 5 cycles, then done pulses once and data_out=0x24; en is ignored throughout.
REQ-042 load with seed_in=0 -> data_out=0x01 and seed_err pulses once; load with seed_in=0x55 -> data_out=0x55 and wrap follows 127 steps later.
REQ-043 load asserted on the 3rd cycle of a burst_len=10 burst -> busy drops, no done pulse, data_out=seed_in.
REQ-044 rst_n pulsed low mid-burst -> immediate data_out=0x01, busy=0, with no clock edge required.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type and default tap mask for the LFSR generator
package lfsr_pkg;
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
    localparam logic [6:0] DEFAULT_TAPS = 7'b1000100;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational one-step Fibonacci LFSR shift
// ports: cur (present register), nxt (register after one step)
module lfsr_step #(
    parameter int WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS = lfsr_pkg::DEFAULT_TAPS
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);
    assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: LFSR generator with load, free-run and counted burst stepping, wrap/period tracking
// ports: clk, rst_n (async active-low); en free-run step; load/seed_in reseed;
//        burst_start/burst_len counted burst; data_out register; busy in burst;
//        done/wrap/seed_err one-cycle pulses; period length of last completed cycle
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS = DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             seed_err
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, origin_q, origin_d, cnt_q, cnt_d, period_q, period_d, nxt, ld_val;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic done_q, done_d, wrap_q, wrap_d, seed_err_q, seed_err_d, step;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (.cur(sreg_q), .nxt(nxt));

    assign ld_val = (seed_in == '0) ? SEED : seed_in;

    always_comb begin
        state_d = state_q;
        sreg_d = sreg_q;
        origin_d = origin_q;
        cnt_d = cnt_q;
        period_d = period_q;
        rem_d = rem_q;
        wrap_d = 1'b0;
        seed_err_d = 1'b0;
        step = 1'b0;
        if (load) begin
            sreg_d = ld_val;
            origin_d = ld_val;
            cnt_d = '0;
            seed_err_d = (seed_in == '0);
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (burst_start) begin
                        state_d = (burst_len == '0) ? DONE : BURST;
                        rem_d = burst_len;
                    end else begin
                        step = en;
                    end
                end
                BURST: begin
                    step = 1'b1;
                    rem_d = rem_q - 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? DONE : BURST;
                end
                default: state_d = IDLE;
            endcase
        end
        if (step) begin
            sreg_d = nxt;
            wrap_d = (nxt == origin_q);
            period_d = wrap_d ? cnt_q + 1'b1 : period_q;
            cnt_d = wrap_d ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
        end
        // done is high exactly while the FSM sits in DONE
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q <= SEED;
            origin_q <= SEED;
            cnt_q <= '0;
            period_q <= '0;
            rem_q <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q <= sreg_d;
            origin_q <= origin_d;
            cnt_q <= cnt_d;
            period_q <= period_d;
            rem_q <= rem_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign data_out = sreg_q;
    assign busy = (state_q == BURST);
    assign done = done_q;
    assign wrap = wrap_q;
    assign period = period_q;
    assign seed_err = seed_err_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed self-checking bench for lfsr_gen (WIDTH=7, TAPS=7'b1000100, SEED=1)
module tb_lfsr_gen;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, burst_start = 1'b0;
    logic [6:0] seed_in = '0, data_out, period;
    logic [7:0] burst_len = '0;
    logic busy, done, wrap, seed_err;
    int checks = 0, errors = 0;

    lfsr_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
        .burst_start(burst_start), .burst_len(burst_len), .data_out(data_out),
        .busy(busy), .done(done), .wrap(wrap), .period(period), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({data_out, busy, done, wrap, period, seed_err} !== {7'h01, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset: data=%h busy=%b done=%b wrap=%b period=%0d seed_err=%b, want 01 0 0 0 0 0",
                     data_out, busy, done, wrap, period, seed_err);
        end
    endtask

    task automatic test_en_steps();
        logic [6:0] exp [3] = '{7'h02, 7'h04, 7'h09};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data_out !== exp[i]) begin
                errors++;
                $display("FAIL en_step%0d: data=%h want %h", i, data_out, exp[i]);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (data_out !== 7'h09) begin
            errors++;
            $display("FAIL en_hold: data=%h want 09", data_out);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (wrap) pulses++;
        end
        checks++;
        if ({wrap, data_out, period} !== {1'b1, 7'h01, 7'd127}) begin
            errors++;
            $display("FAIL wrap127: wrap=%b data=%h period=%0d want 1 01 127", wrap, data_out, period);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL wrap_count: pulses=%0d want 1", pulses);
        end
        en = 1'b0;
        tick();
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_one_cycle: wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_burst();
        int busy_cycles = 0;
        do_reset();
        en = 1'b1;
        burst_start = 1'b1;
        burst_len = 8'd5;
        tick();
        burst_start = 1'b0;
        checks++;
        if (data_out !== 7'h01) begin
            errors++;
            $display("FAIL burst_no_step_on_start: data=%h want 01", data_out);
        end
        for (int i = 0; i < 5; i++) begin
            if (busy) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles !== 5) begin
            errors++;
            $display("FAIL burst_busy_cycles: got %0d want 5", busy_cycles);
        end
        checks++;
        if ({busy, done, data_out} !== {1'b0, 1'b1, 7'h24}) begin
            errors++;
            $display("FAIL burst_done: busy=%b done=%b data=%h want 0 1 24", busy, done, data_out);
        end
        tick();
        checks++;
        if ({done, data_out} !== {1'b0, 7'h24}) begin
            errors++;
            $display("FAIL burst_after_done: done=%b data=%h want 0 24", done, data_out);
        end
        en = 1'b0;
        burst_start = 1'b1;
        burst_len = 8'd0;
        tick();
        burst_start = 1'b0;
        checks++;
        if ({busy, done, data_out} !== {1'b0, 1'b1, 7'h24}) begin
            errors++;
            $display("FAIL burst_zero: busy=%b done=%b data=%h want 0 1 24", busy, done, data_out);
        end
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        load = 1'b1;
        seed_in = 7'h00;
        tick();
        load = 1'b0;
        checks++;
        if ({data_out, seed_err} !== {7'h01, 1'b1}) begin
            errors++;
            $display("FAIL load_zero: data=%h seed_err=%b want 01 1", data_out, seed_err);
        end
        tick();
        checks++;
        if (seed_err !== 1'b0) begin
            errors++;
            $display("FAIL seed_err_pulse: seed_err=%b want 0", seed_err);
        end
        load = 1'b1;
        seed_in = 7'h55;
        tick();
        load = 1'b0;
        checks++;
        if ({data_out, seed_err} !== {7'h55, 1'b0}) begin
            errors++;
            $display("FAIL load_55: data=%h seed_err=%b want 55 0", data_out, seed_err);
        end
        en = 1'b1;
        for (int i = 0; i < 126; i++) begin
            tick();
            checks++;
            if (wrap !== 1'b0) begin
                errors++;
                $display("FAIL load_early_wrap: step %0d wrap=%b want 0", i + 1, wrap);
            end
        end
        tick();
        en = 1'b0;
        checks++;
        if ({wrap, data_out, period} !== {1'b1, 7'h55, 7'd127}) begin
            errors++;
            $display("FAIL load_wrap: wrap=%b data=%h period=%0d want 1 55 127", wrap, data_out, period);
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        do_reset();
        burst_start = 1'b1;
        burst_len = 8'd10;
        tick();
        burst_start = 1'b0;
        repeat (2) tick();
        load = 1'b1;
        seed_in = 7'h3c;
        tick();
        load = 1'b0;
        checks++;
        if ({busy, done, data_out} !== {1'b0, 1'b0, 7'h3c}) begin
            errors++;
            $display("FAIL abort_load: busy=%b done=%b data=%h want 0 0 3c", busy, done, data_out);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen++;
        end
        checks++;
        if ({done_seen, data_out} !== {32'd0, 7'h3c}) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d data=%h want 0 3c", done_seen, data_out);
        end
    endtask

    task automatic test_async_reset();
        int done_seen = 0;
        do_reset();
        burst_start = 1'b1;
        burst_len = 8'd10;
        tick();
        burst_start = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, busy} !== {7'h01, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: data=%h busy=%b want 01 0", data_out, busy);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen++;
        end
        checks++;
        if ({done_seen, data_out} !== {32'd0, 7'h01}) begin
            errors++;
            $display("FAIL async_reset_abandon: done pulses=%0d data=%h want 0 01", done_seen, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_en_steps();
        test_wrap();
        test_burst();
        test_load();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
